// File: rtl/pit_shared_timer_scheduler.sv
// Shared prescaled one-shot timer: round-robin grants one requester at a time,
// counts its N ticks and pulses that requester's done line plus irq on expiry.
module pit_shared_timer_scheduler #(
  parameter int unsigned  NUM_REQ    = 4,
  parameter int unsigned  COUNT_W    = 16,
  parameter int unsigned  PRESCALE_W = 8,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       abort_i,
  input  logic [PRESCALE_W-1:0]      prescale_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*COUNT_W-1:0] req_count_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         done_pulse_o,
  output logic                       irq_o,
  output logic                       busy_o,
  output logic [ID_W-1:0]            active_id_o,
  output logic [COUNT_W-1:0]         remaining_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [COUNT_W-1:0]    cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_W-1:0] pre_lat_q, pre_lat_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  irq_q, irq_d;
  logic                  busy_q, busy_d;
  logic [COUNT_W-1:0]    rem_q, rem_d;

  logic [COUNT_W-1:0]    req_cnt_arr [NUM_REQ];
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       scan_id;
  logic [ID_W-1:0]       next_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_slice
    assign req_cnt_arr[g] = req_count_i[g*COUNT_W +: COUNT_W];
  end

  // Round-robin pick: first valid requester at or above rr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_id = ID_W'((32'(rr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign next_id = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    pre_cnt_d   = pre_cnt_q;
    pre_lat_d   = pre_lat_q;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && grant_found && !reset_i) begin
          req_ready_o = NUM_REQ'(1) << grant_id;
          id_d        = grant_id;
          cnt_d       = req_cnt_arr[grant_id];
          pre_lat_d   = prescale_i;
          pre_cnt_d   = '0;
          state_d     = (req_cnt_arr[grant_id] != '0) ? ST_RUN : ST_FIRE;
        end
      end
      ST_RUN: begin
        // Abort takes priority over an expiry tick in the same cycle.
        if (abort_i) begin
          state_d = ST_IDLE;
          rr_d    = next_id;
        end else if (enable_i) begin
          if (pre_cnt_q == pre_lat_q) begin
            pre_cnt_d = '0;
            cnt_d     = cnt_q - COUNT_W'(1);
            if (cnt_q == COUNT_W'(1)) state_d = ST_FIRE;
          end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
          end
        end
      end
      ST_FIRE: begin
        rr_d    = next_id;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_FIRE) ? (NUM_REQ'(1) << id_d) : '0;
    irq_d  = (state_d == ST_FIRE);
    busy_d = (state_d != ST_IDLE);
    rem_d  = (state_d == ST_RUN) ? cnt_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      pre_cnt_q <= '0;
      pre_lat_q <= '0;
      done_q    <= '0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      pre_lat_q <= pre_lat_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
      rem_q     <= rem_d;
    end
  end

  assign done_pulse_o = done_q;
  assign irq_o        = irq_q;
  assign busy_o       = busy_q;
  assign active_id_o  = id_q;
  assign remaining_o  = rem_q;

endmodule

// File: tb/tb_pit_shared_timer_scheduler.sv
// Bench for pit_shared_timer_scheduler: directed scenarios plus random traffic,
// checked by a tick-budget reference model and a done-pulse scoreboard.
module tb_pit_shared_timer_scheduler;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned COUNT_W    = 16;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned ID_W       = 2;

  logic                       clk = 1'b0;
  logic                       reset_i = 1'b1;
  logic                       enable_i = 1'b0;
  logic                       abort_i = 1'b0;
  logic [PRESCALE_W-1:0]      prescale_i = '0;
  logic [NUM_REQ-1:0]         req_valid_i = '0;
  logic [NUM_REQ*COUNT_W-1:0] req_count_i = '0;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         done_pulse_o;
  logic                       irq_o;
  logic                       busy_o;
  logic [ID_W-1:0]            active_id_o;
  logic [COUNT_W-1:0]         remaining_o;

  pit_shared_timer_scheduler #(
    .NUM_REQ(NUM_REQ), .COUNT_W(COUNT_W), .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .abort_i(abort_i),
    .prescale_i(prescale_i), .req_valid_i(req_valid_i), .req_count_i(req_count_i),
    .req_ready_o(req_ready_o), .done_pulse_o(done_pulse_o), .irq_o(irq_o),
    .busy_o(busy_o), .active_id_o(active_id_o), .remaining_o(remaining_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int due; } exp_t;
  exp_t sb_q[$];
  int   grant_q[$];
  int   hs_q[$];
  int   done_cnt [NUM_REQ];
  int   last_done [NUM_REQ];
  int   last_hs [NUM_REQ];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: 0 idle, 1 counting, 2 firing; work = enabled cycles left.
  int m_st = 0, m_rr = 0, m_id = 0, m_work = 0, m_plat = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
    for (int i = 0; i < NUM_REQ; i++)
      if (v[(rr + i) % NUM_REQ]) return (rr + i) % NUM_REQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int   g, n;
    exp_t e;
    exp_rdy = '0;
    g = pick(req_valid_i, m_rr);
    if (!reset_i && m_st == 0 && enable_i && g >= 0) exp_rdy = NUM_REQ'(1) << g;
    check("req_ready", req_ready_o, exp_rdy);
    check("busy", busy_o, (m_st != 0) ? 1 : 0);
    check("irq", irq_o, (m_st == 2) ? 1 : 0);
    check("active_id", active_id_o, m_id);
    check("remaining", remaining_o, (m_st == 1) ? (m_work + m_plat) / (m_plat + 1) : 0);
    if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      check("done_missing", -1, e.id);
    end
    if (done_pulse_o != '0) begin
      if (sb_q.size() == 0) check("done_unexpected", done_pulse_o, 0);
      else begin
        e = sb_q.pop_front();
        check("done_id", done_pulse_o, NUM_REQ'(1) << e.id);
        check("done_cycle", cyc, e.due);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (done_pulse_o[i]) begin done_cnt[i]++; last_done[i] = cyc; end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready_o[i]) begin last_hs[i] = cyc; grant_q.push_back(i); hs_q.push_back(cyc); end
    // Advance the model with the inputs the DUT samples at the coming edge.
    if (reset_i) begin
      m_st = 0; m_rr = 0; m_id = 0; m_work = 0; m_plat = 0;
    end else begin
      case (m_st)
        0: if (enable_i && g >= 0) begin
          m_id   = g;
          m_plat = int'(prescale_i);
          n      = int'(req_count_i[g*COUNT_W +: COUNT_W]);
          m_work = n * (m_plat + 1);
          if (n == 0) begin m_st = 2; sb_q.push_back('{g, cyc + 1}); end
          else m_st = 1;
        end
        1: if (abort_i) begin
          m_st = 0; m_rr = (m_id + 1) % NUM_REQ;
        end else if (enable_i) begin
          m_work--;
          if (m_work == 0) begin m_st = 2; sb_q.push_back('{m_id, cyc + 1}); end
        end
        default: begin m_st = 0; m_rr = (m_id + 1) % NUM_REQ; end
      endcase
    end
  end

  task automatic step();
    logic [NUM_REQ-1:0] rdy;
    @(negedge clk);
    rdy = req_ready_o;
    @(posedge clk);
    #1;
    req_valid_i = req_valid_i & ~rdy;
  endtask

  task automatic post(input int id, input int n);
    req_count_i[id*COUNT_W +: COUNT_W] = COUNT_W'(n);
    req_valid_i[id] = 1'b1;
  endtask

  task automatic clr_log();
    for (int i = 0; i < NUM_REQ; i++) begin last_hs[i] = -100000; last_done[i] = -1; end
    grant_q.delete();
    hs_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (req_valid_i == '0 && !busy_o) begin ok = 1; break; end
    end
    check("wait_idle_timeout", ok, 1);
  endtask

  // rem < 0: wait for busy only; otherwise also for that remaining value.
  task automatic wait_run(input int rem, input int budget);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (busy_o && (rem < 0 || int'(remaining_o) == rem)) begin ok = 1; break; end
    end
    check("wait_run_timeout", ok, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_irq"}, irq_o, 0);
    check({tag, "_done"}, done_pulse_o, 0);
    check({tag, "_remaining"}, remaining_o, 0);
    check({tag, "_active_id"}, active_id_o, 0);
    check({tag, "_ready"}, req_ready_o, 0);
  endtask

  initial begin
    int d0, d2, d3;
    bit reposted;
    for (int i = 0; i < NUM_REQ; i++) done_cnt[i] = 0;
    clr_log();
    repeat (3) step();
    check_zero_outputs("reset");
    reset_i = 1'b0;
    enable_i = 1'b1;

    // 1: N=3 P=0 -> done 4 cycles after handshake
    clr_log(); prescale_i = 8'd0; post(0, 3); wait_idle(50);
    check("t1_latency", last_done[0] - last_hs[0], 4);

    // 2: N=2 P=4, prescale changed mid-run has no effect
    clr_log(); prescale_i = 8'd4; post(1, 2); wait_run(-1, 20);
    prescale_i = 8'd0; wait_idle(100);
    check("t2_latency", last_done[1] - last_hs[1], 11);

    // 3: all four requesters from reset, N=1 P=0, req0 re-posts
    reset_i = 1'b1; step(); step(); reset_i = 1'b0;
    clr_log(); prescale_i = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) post(i, 1);
    reposted = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!reposted && !req_valid_i[0]) begin post(0, 1); reposted = 1; end
      if (reposted && req_valid_i == '0 && !busy_o) break;
    end
    wait_idle(50);
    check("t3_grants", grant_q.size(), 5);
    for (int k = 0; k < 5; k++)
      check("t3_order", (k < grant_q.size()) ? grant_q[k] : -1, k % NUM_REQ);
    for (int k = 1; k < 5; k++)
      check("t3_spacing", (k < hs_q.size()) ? hs_q[k] - hs_q[k-1] : -1, 3);
    for (int i = 0; i < NUM_REQ; i++) check("t3_latency", last_done[i] - last_hs[i], 2);

    // 4: N=5 P=1 with 7 paused cycles; enable=0 in idle blocks grants
    clr_log(); prescale_i = 8'd1; post(2, 5); wait_run(-1, 20);
    step(); step(); enable_i = 1'b0;
    repeat (7) step();
    enable_i = 1'b1; wait_idle(100);
    check("t4_latency", last_done[2] - last_hs[2], 18);
    enable_i = 1'b0; post(1, 1);
    repeat (3) step();
    check("t4_ready_paused", req_ready_o, 0);
    check("t4_busy_paused", busy_o, 0);
    enable_i = 1'b1; wait_idle(20);

    // 5: abort at remaining=2, then rr resumes after the aborted id, then abort on final tick
    clr_log(); prescale_i = 8'd0; d3 = done_cnt[3];
    post(3, 4); wait_run(2, 20);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check("t5_abort_busy", busy_o, 0);
    post(2, 0); post(0, 0); wait_idle(20);
    check("t5_abort_nodone", done_cnt[3] - d3, 0);
    check("t5_rr_after_abort", (grant_q.size() > 1) ? grant_q[1] : -1, 0);
    d2 = done_cnt[2];
    post(2, 2); wait_run(1, 20);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check("t5_final_abort_busy", busy_o, 0);
    repeat (3) step();
    check("t5_final_abort_nodone", done_cnt[2] - d2, 0);

    // 6: N=0 immediate fire, then reset mid-run
    clr_log(); post(3, 0); wait_idle(20);
    check("t6_zero_latency", last_done[3] - last_hs[3], 1);
    d0 = done_cnt[0];
    post(0, 5); wait_run(-1, 20); step(); step();
    reset_i = 1'b1; step();
    check_zero_outputs("t6_midreset");
    reset_i = 1'b0;
    repeat (8) step();
    check("t6_midreset_nodone", done_cnt[0] - d0, 0);

    // 7: random traffic
    for (int k = 0; k < 600; k++) begin
      enable_i   = ($urandom_range(0, 9) != 0);
      abort_i    = ($urandom_range(0, 29) == 0);
      prescale_i = PRESCALE_W'($urandom_range(0, 3));
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid_i[i] && $urandom_range(0, 7) == 0) post(i, int'($urandom_range(0, 6)));
      step();
    end
    enable_i = 1'b1; abort_i = 1'b0;
    wait_idle(3000);
    repeat (3) step();
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
